// File: rtl/bpu_btb_bht.sv
// Direct-mapped BTB with per-entry saturating-counter BHT; combinational lookup and mispredict, update on clk.
// Optional statistics counters are built only when BPU_STATS_EN is defined.
module bpu_btb_bht #(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic [31:0] pc_if_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_pred_taken_i,
  input  logic [31:0] upd_pred_target_i,
  output logic        mispredict_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispredict_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [ENTRIES-1:0] valid_q;
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit, commit;

  assign lk_idx = pc_if_i[IDX_W+1:2];
  assign lk_tag = pc_if_i[31:IDX_W+2];
  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[31:IDX_W+2];

  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign commit = upd_valid_i && !stall_i;

  assign pred_taken_o  = lk_hit && cnt_q[lk_idx][CNT_W-1];
  assign pred_target_o = pred_taken_o ? target_q[lk_idx] : pc_if_i + 32'd4;

  // Resolution path ignores stall so the controller can flush while frozen.
  assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + 32'd4;
  assign mispredict_o  = upd_valid_i && (redirect_pc_o != upd_pred_target_i);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= WEAK_T - CNT_W'(1);
    end else if (commit) begin
      if (up_hit) begin
        if (upd_taken_i) begin
          if (cnt_q[up_idx] != CNT_MAX) cnt_q[up_idx] <= cnt_q[up_idx] + CNT_W'(1);
        end else if (cnt_q[up_idx] != '0) begin
          cnt_q[up_idx] <= cnt_q[up_idx] - CNT_W'(1);
        end
      end else if (upd_taken_i) begin
        valid_q[up_idx] <= 1'b1;
        cnt_q[up_idx]   <= WEAK_T;
      end
    end
  end

  // Tag and target need no reset: they are qualified by valid.
  always_ff @(posedge clk) begin
    if (rst_n && commit && upd_taken_i) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= upd_target_i;
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] branch_cnt_q, mispredict_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (commit) begin
      if (branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict_o && mispredict_cnt_q != 32'hFFFF_FFFF)
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;
`else
  assign branch_cnt_o     = 32'd0;
  assign mispredict_cnt_o = 32'd0;
`endif

  // Low PC bits and the carried direction bit play no part in prediction.
  logic unused_ok;
  assign unused_ok = ^{pc_if_i[1:0], upd_pc_i[1:0], upd_pred_taken_i};

endmodule

// File: tb/tb_bpu_btb_bht.sv
// Scoreboarded bench for bpu_btb_bht against an array-based reference model (ENTRIES=64, CNT_W=2).
module tb_bpu_btb_bht;

  logic        clk = 1'b0;
  logic        rst_n, stall_i, upd_valid_i, upd_taken_i, upd_pred_taken_i;
  logic [31:0] pc_if_i, upd_pc_i, upd_target_i, upd_pred_target_i;
  logic        pred_taken_o, mispredict_o;
  logic [31:0] pred_target_o, redirect_pc_o, branch_cnt_o, mispredict_cnt_o;

  always #5 clk = ~clk;

  bpu_btb_bht #(.ENTRIES(64), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .pc_if_i(pc_if_i),
    .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .upd_pred_taken_i(upd_pred_taken_i),
    .upd_pred_target_i(upd_pred_target_i), .mispredict_o(mispredict_o),
    .redirect_pc_o(redirect_pc_o), .branch_cnt_o(branch_cnt_o),
    .mispredict_cnt_o(mispredict_cnt_o)
  );

  typedef struct {
    string       tag;
    logic        pt;
    logic [31:0] ptg;
    logic        mp;
    logic [31:0] rd;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Reference model: one record per table slot, counter kept as an integer.
  bit          m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_cnt   [64];
  logic [31:0] m_bc = 0, m_mc = 0;

  function automatic void model_pred(input logic [31:0] pc, output bit tk, output logic [31:0] tg);
    int i;
    bit hit;
    i   = int'((pc >> 2) % 64);
    hit = m_valid[i] && (m_tag[i] == pc[31:8]);
    tk  = hit && (m_cnt[i] >= 2);
    tg  = tk ? m_tgt[i] : pc + 32'd4;
  endfunction

  task automatic cyc(input bit r, input bit s, input logic [31:0] pcif,
                     input bit uv, input logic [31:0] upc, input bit ut,
                     input logic [31:0] utg, input bit upt, input logic [31:0] uptg,
                     input string nm, input bit chk = 1'b1);
    exp_t e;
    bit tk, hit, mp;
    logic [31:0] tg, rd;
    int i;
    @(posedge clk);
    #1;
    rst_n = r; stall_i = s; pc_if_i = pcif; upd_valid_i = uv; upd_pc_i = upc;
    upd_taken_i = ut; upd_target_i = utg; upd_pred_taken_i = upt; upd_pred_target_i = uptg;
    model_pred(pcif, tk, tg);
    rd = ut ? utg : upc + 32'd4;
    mp = uv && (rd != uptg);
    e.tag = nm; e.pt = tk; e.ptg = tg; e.mp = mp; e.rd = rd;
`ifdef BPU_STATS_EN
    e.bc = m_bc; e.mc = m_mc;
`else
    e.bc = 0; e.mc = 0;
`endif
    if (chk) q.push_back(e);
    // Apply what the coming edge does to the table.
    if (!r) begin
      for (int k = 0; k < 64; k++) begin m_valid[k] = 0; m_cnt[k] = 1; end
      m_bc = 0; m_mc = 0;
    end else if (uv && !s) begin
      if (m_bc != 32'hFFFF_FFFF) m_bc++;
      if (mp && m_mc != 32'hFFFF_FFFF) m_mc++;
      i   = int'((upc >> 2) % 64);
      hit = m_valid[i] && (m_tag[i] == upc[31:8]);
      if (hit) begin
        if (ut) begin
          m_cnt[i] = (m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1;
          m_tgt[i] = utg;
        end else begin
          m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
        end
      end else if (ut) begin
        m_valid[i] = 1; m_tag[i] = upc[31:8]; m_tgt[i] = utg; m_cnt[i] = 2;
      end
    end
  endtask

  task automatic idle(input logic [31:0] pcif, input string nm);
    cyc(1, 0, pcif, 0, 32'h0, 0, 32'h0, 0, 32'h0, nm);
  endtask

  function automatic void cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s got=%h want=%h", nm, fld, act, req);
    end
  endfunction

  // Monitor: the DUT presents a fresh combinational response every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp(e.tag, "pred_taken", {31'd0, pred_taken_o}, {31'd0, e.pt});
      cmp(e.tag, "pred_target", pred_target_o, e.ptg);
      cmp(e.tag, "mispredict", {31'd0, mispredict_o}, {31'd0, e.mp});
      cmp(e.tag, "redirect", redirect_pc_o, e.rd);
      cmp(e.tag, "branch_cnt", branch_cnt_o, e.bc);
      cmp(e.tag, "mispred_cnt", mispredict_cnt_o, e.mc);
    end
  end

  initial begin
    bit tk;
    logic [31:0] tg, pc, upc, utg, ptg;
    bit ut, upt;
    rst_n = 0; stall_i = 0; pc_if_i = 0; upd_valid_i = 0; upd_pc_i = 0;
    upd_taken_i = 0; upd_target_i = 0; upd_pred_taken_i = 0; upd_pred_target_i = 0;

    cyc(0, 0, 32'h100, 0, 0, 0, 0, 0, 0, "rst", 1'b0);
    cyc(0, 0, 32'h100, 0, 0, 0, 0, 0, 0, "rst_out");
    idle(32'h100, "after_rst");
    cyc(1, 0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h104, "first_alloc");
    idle(32'h100, "alloc_visible");
    for (int k = 0; k < 3; k++) cyc(1, 0, 32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200, "sat_up");
    for (int k = 0; k < 2; k++) cyc(1, 0, 32'h100, 1, 32'h100, 0, 32'h200, 1, 32'h200, "dec");
    idle(32'h100, "cnt1_nt");
    for (int k = 0; k < 2; k++) cyc(1, 0, 32'h100, 1, 32'h100, 0, 32'h200, 0, 32'h104, "sat_dn");
    cyc(1, 0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h104, "cnt0_up");
    idle(32'h100, "cnt1_again");
    cyc(1, 0, 32'h100, 1, 32'h200, 1, 32'h300, 0, 32'h204, "alias");
    idle(32'h100, "alias_evict");
    idle(32'h200, "alias_new");
    for (int k = 0; k < 3; k++) cyc(1, 1, 32'h140, 1, 32'h140, 1, 32'h500, 0, 32'h144, "stall");
    idle(32'h140, "stall_none");
    cyc(1, 0, 32'h140, 1, 32'h140, 1, 32'h500, 0, 32'h144, "stall_rel");
    idle(32'h140, "stall_one");
    cyc(1, 0, 32'h140, 1, 32'h140, 1, 32'h600, 1, 32'h500, "hazard_old");
    idle(32'h140, "hazard_new");
    cyc(0, 0, 32'h180, 1, 32'h180, 1, 32'h700, 0, 32'h184, "rst_upd");
    idle(32'h180, "rst_no_alloc");
    idle(32'h140, "rst_wiped");
    idle(32'hFFFF_FFFC, "wrap");

    for (int n = 0; n < 600; n++) begin
      pc  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      upc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      ut  = ($urandom_range(0, 99) < 60);
      utg = 32'($urandom_range(0, 15)) << 4;
      model_pred(upc, tk, tg);
      if ($urandom_range(0, 9) < 7) begin upt = tk; ptg = tg; end
      else begin upt = $urandom_range(0, 1) != 0; ptg = $urandom; end
      cyc(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1, $urandom_range(0, 9) < 2, pc,
          $urandom_range(0, 9) < 8, upc, ut, utg, upt, ptg, "rand");
    end

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
